// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one word-aligned fetch at a time into a small
// prefetch FIFO, and flushes the FIFO and redirects the fetch stream on a taken branch.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic [31:0]              req_pc_q, req_pc_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][31:0]   data_q, data_d, pc_q, pc_d;
  logic                     fire, push, pop;

  // A request is never offered in the redirect cycle, so a stale fetch_pc cannot escape.
  assign imem_req_valid = rst_n && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = {fetch_pc_q[31:2], 2'b00};
  assign inst_valid     = (count_q != '0);
  assign inst           = data_q[rd_ptr_q];
  assign inst_pc        = pc_q[rd_ptr_q];

  assign fire = imem_req_valid && imem_req_ready;
  assign push = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (fire) state_d = WAIT;
      WAIT: begin
        if (imem_resp_valid)     state_d = IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: if (imem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    if (fire) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (push) begin
      data_d[wr_ptr_q] = imem_resp_data;
      pc_d[wr_ptr_q]   = req_pc_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
    // Flush overrides everything else this cycle, including a concurrent pop.
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      data_q     <= '0;
      pc_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed per-cycle vectors for ifetch_unit plus a hand-written mid-request reset sequence.
module tb_ifetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int nchecks = 0;
  int nerrors = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        irdy, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic rv, input logic [31:0] rdata,
                     input logic irdy, input logic redir, input logic [31:0] rpc,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.irdy = irdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_iv, input logic [31:0] e_inst, input logic [31:0] e_pc);
    chk({tag, ".req_valid"}, {31'd0, imem_req_valid}, {31'd0, e_req});
    chk({tag, ".req_addr"},  imem_req_addr, e_addr);
    chk({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, e_iv});
    if (e_iv) begin
      chk({tag, ".inst"},    inst, e_inst);
      chk({tag, ".inst_pc"}, inst_pc, e_pc);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rdata,
                       input logic irdy, input logic redir, input logic [31:0] rpc);
    imem_req_ready = rdy; imem_resp_valid = rv; imem_resp_data = rdata;
    inst_ready = irdy; redirect_valid = redir; redirect_pc = rpc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);

    //   rdy rv rdata          irdy rd rpc            e_req e_addr         e_iv e_inst         e_pc
    // basic fetch, FIFO fill to DEPTH, pop reopens the request
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 0, 32'h0,          32'h0);          // v0
    add(1, 1, 32'h2008_0005,  0, 0, 32'h0,          0, 32'h0000_0004, 0, 32'h0,          32'h0);          // v1
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0004, 1, 32'h2008_0005, 32'h0000_0000); // v2
    add(1, 1, 32'h1111_0004,  0, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h2008_0005, 32'h0000_0000); // v3
    add(1, 1, 32'hEEEE_EEEE,  0, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h2008_0005, 32'h0000_0000); // v4 full
    add(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0000_0008, 1, 32'h2008_0005, 32'h0000_0000); // v5 pop
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0008, 1, 32'h1111_0004, 32'h0000_0004); // v6
    // redirect while waiting, response dropped
    add(0, 0, 32'h0,          0, 1, 32'h0000_0040,  0, 32'h0000_000C, 1, 32'h1111_0004, 32'h0000_0004); // v7
    add(0, 1, 32'hDEAD_0008,  0, 0, 32'h0,          0, 32'h0000_0040, 0, 32'h0,          32'h0);          // v8
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0040, 0, 32'h0,          32'h0);          // v9
    add(1, 1, 32'h0000_0A40,  0, 0, 32'h0,          0, 32'h0000_0044, 0, 32'h0,          32'h0);          // v10
    add(0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0000_0044, 1, 32'h0000_0A40, 32'h0000_0040); // v11
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0044, 0, 32'h0,          32'h0);          // v12
    // redirect coincident with response; unaligned target
    add(0, 1, 32'hBAD0_0044,  0, 1, 32'h0000_0102,  0, 32'h0000_0048, 0, 32'h0,          32'h0);          // v13
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0100, 0, 32'h0,          32'h0);          // v14
    add(1, 1, 32'h0000_0100,  0, 0, 32'h0,          0, 32'h0000_0104, 0, 32'h0,          32'h0);          // v15
    // redirect same cycle as pop: flush wins; then address wrap
    add(1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  0, 32'h0000_0104, 1, 32'h0000_0100, 32'h0000_0100); // v16
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'hFFFF_FFFC, 0, 32'h0,          32'h0);          // v17
    add(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,          32'h0);          // v18
    add(0, 1, 32'h5555_FFFC,  0, 0, 32'h0,          0, 32'h0000_0000, 0, 32'h0,          32'h0);          // v19
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h5555_FFFC, 32'hFFFF_FFFC); // v20
    // redirect into DROP, second redirect in DROP only moves fetch_pc
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0000, 1, 32'h5555_FFFC, 32'hFFFF_FFFC); // v21
    add(0, 0, 32'h0,          0, 1, 32'h0000_0200,  0, 32'h0000_0004, 1, 32'h5555_FFFC, 32'hFFFF_FFFC); // v22
    add(0, 0, 32'h0,          0, 1, 32'h0000_0300,  0, 32'h0000_0200, 0, 32'h0,          32'h0);          // v23
    add(0, 1, 32'hBAD0_0000,  0, 0, 32'h0,          0, 32'h0000_0300, 0, 32'h0,          32'h0);          // v24
    add(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0300, 0, 32'h0,          32'h0);          // v25
    add(0, 1, 32'h0000_0304,  0, 0, 32'h0,          0, 32'h0000_0304, 0, 32'h0,          32'h0);          // v26
    add(0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h0000_0304, 1, 32'h0000_0304, 32'h0000_0300); // v27

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_all("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("reset.inst", inst, 32'h0);
    chk("reset.inst_pc", inst_pc, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rdy, vq[i].rv, vq[i].rdata, vq[i].irdy, vq[i].redir, vq[i].rpc);
      #1;
      chk_all($sformatf("v%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_iv, vq[i].e_inst, vq[i].e_pc);
    end

    // reset mid-WAIT with one entry buffered, then a stale response after release
    @(negedge clk); drive(1, 0, 32'h0, 0, 0, 32'h0);  // request 0x304 accepted at next edge
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1; chk("pre_rst.inst_valid", {31'd0, inst_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 32'h0, 0, 32'h0, 32'h0);
    chk("async_rst.inst", inst, 32'h0);
    chk("async_rst.inst_pc", inst_pc, 32'h0);
    @(negedge clk); rst_n = 1'b1; drive(0, 1, 32'hBAD0_0304, 0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1; chk_all("post_rst", 1, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk); drive(1, 0, 32'h0, 0, 0, 32'h0);
    #1; chk_all("post_rst.req", 1, 32'h0, 0, 32'h0, 32'h0);
    @(negedge clk); drive(0, 1, 32'h0000_0077, 0, 0, 32'h0);
    #1; chk_all("post_rst.wait", 0, 32'h4, 0, 32'h0, 32'h0);
    @(negedge clk); drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1; chk_all("post_rst.head", 1, 32'h4, 1, 32'h0000_0077, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, 2, prefetch FIFO entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word address of request.
REQ-008 SHALL have port imem_resp_valid  input  1  response data valid, at least 1 cycle after acceptance.
REQ-009 SHALL have port imem_resp_data  input  32  fetched instruction word.
REQ-010 SHALL have port inst_valid  output  1  FIFO head valid toward CPU.
REQ-011 SHALL have port inst_ready  input  1  CPU consumes head.
REQ-012 SHALL have port inst  output  32  head instruction word.
REQ-013 SHALL have port inst_pc  output  32  address of head instruction.
REQ-014 SHALL have port redirect_valid  input  1  CPU branch/jump/jr taken.
REQ-015 SHALL have port redirect_pc  input  32  new fetch target (CPU pc_new).

Function
REQ-016 SHALL keep fetch_pc register; imem_req_addr = {fetch_pc[31:2],2'b00}.
REQ-017 SHALL implement FSM states IDLE, WAIT, DROP; at most one outstanding request.
REQ-018 SHALL assert imem_req_valid only when state==IDLE, count<DEPTH, redirect_valid==0.
REQ-019 SHALL, on imem_req_valid&imem_req_ready: latch req_pc=fetch_pc, fetch_pc+=4 (mod 2^32 wrap), IDLE->WAIT.
REQ-020 SHALL, in WAIT with imem_resp_valid and no redirect: push {req_pc, imem_resp_data}, WAIT->IDLE; next request no earlier than following cycle.
REQ-021 SHALL ignore imem_resp_valid in IDLE.
REQ-022 SHALL drive inst_valid=(count!=0), inst/inst_pc from FIFO head registers (no combinational path from imem_resp_*).
REQ-023 SHALL pop head on inst_valid&inst_ready; push and pop same cycle leaves count unchanged.
REQ-024 SHALL never overflow: request gated by count<DEPTH, single outstanding, so push only when count<DEPTH at issue or pop occurred.
REQ-025 SHALL, on redirect_valid (highest priority): flush FIFO (count=0, pointers reset), fetch_pc={redirect_pc[31:2],2'b00}.
REQ-026 SHALL, on redirect in WAIT without imem_resp_valid: WAIT->DROP; with imem_resp_valid same cycle: discard data, WAIT->IDLE.
REQ-027 SHALL, in DROP: discard next imem_resp_valid, DROP->IDLE; further redirect in DROP only updates fetch_pc.
REQ-028 SHALL, on redirect same cycle as pop: flush wins; count=0 next cycle.
REQ-029 SHALL, on redirect in IDLE: stay IDLE, first request with new fetch_pc next cycle.

Reset
REQ-030 SHALL, while rst_n==0: fetch_pc=RESET_PC, state=IDLE, count=0, inst_valid=0, inst=0, inst_pc=0, imem_req_valid=0.
REQ-031 SHALL abort any outstanding request on reset; response arriving after rst_n release while IDLE is ignored.

Verification
REQ-032 Reset release, ready=1, resp 1 cycle after accept with data 0x2008_0005 -> first req addr 0x0, inst_valid, inst=0x2008_0005, inst_pc=0x0; next req addr 0x4.
REQ-033 inst_ready=0, memory always responds -> exactly DEPTH=2 entries (pc 0x0,0x4), imem_req_valid low; one pop -> request 0x8 issued next cycle.
REQ-034 Redirect to 0x0000_0040 while WAIT on 0x8, response next cycle -> response dropped, FIFO empty, next req addr 0x40, inst_pc=0x40.
REQ-035 Redirect to 0x0000_0102 same cycle as resp_valid -> data discarded, next req addr 0x100.
REQ-036 fetch_pc=0xFFFF_FFFC accepted -> next req addr 0x0000_0000.
REQ-037 rst_n low mid-WAIT -> outputs zero immediately; post-reset req addr RESET_PC; stale response ignored.
